// File: rtl/tx_enc_pkg.sv
// tx_enc_pkg: shared widths, scheduler state encoding and the 7b checksum helper
package tx_enc_pkg;
    localparam int DATA_W = 7;
    localparam int CHK_W  = 3;
    localparam int CODE_W = 10;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;
    function automatic logic [CHK_W-1:0] chk_of(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) n = n + {2'b00, data[i]};
        return ~n;
    endfunction
endpackage

// File: rtl/tx_chk_encoder.sv
// tx_chk_encoder: combinational 7b -> 10b codeword {~popcount(data), data}
module tx_chk_encoder
    import tx_enc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code
);
    assign code = {chk_of(data), data};
endmodule

// File: rtl/tx_encode_scheduler.sv
// tx_encode_scheduler: round-robin share of one checksum encoder and serial TX line
module tx_encode_scheduler
    import tx_enc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_bit,
    output logic                      tx_en,
    output logic [CODE_W-1:0]         tx_word,
    output logic [2:0]                tx_src,
    output logic                      busy,
    output logic                      frame_done
);
    state_t              state, next_state;
    logic [2:0]          rr_ptr, off, gnt_idx;
    logic [3:0]          sum, bit_cnt, gap_cnt;
    logic [NUM_REQ-1:0]  rot;
    logic                found, accept;
    logic [DATA_W-1:0]   win_data;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-2:0]   sh;

    // rotate valids so bit 0 is the requester at rr_ptr, then take the lowest set bit
    always_comb begin
        rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        found = |rot;
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = 3'(k);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        gnt_idx = 3'(sum >= 4'(NUM_REQ) ? sum - 4'(NUM_REQ) : sum);
        accept = (state == IDLE) && found;
        req_ready = accept ? NUM_REQ'(1) << gnt_idx : '0;
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) if (gnt_idx == 3'(k)) win_data = req_data[DATA_W*k +: DATA_W];
    end

    tx_chk_encoder u_enc (
        .data (win_data),
        .code (code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? SHIFT : IDLE;
            SHIFT:   next_state = (bit_cnt == 4'd9) ? (GAP_CYCLES == 0 ? IDLE : GAP) : SHIFT;
            GAP:     next_state = (gap_cnt == 4'(GAP_CYCLES - 1)) ? IDLE : GAP;
            default: next_state = IDLE;
        endcase
    end

    // outputs are registered from next_state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sh         <= '0;
            tx_word    <= '0;
            tx_src     <= '0;
            tx_bit     <= 1'b0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == SHIFT) && (bit_cnt == 4'd9);
            busy       <= next_state != IDLE;
            tx_en      <= next_state == SHIFT;
            if (accept) begin
                tx_word <= code;
                tx_src  <= gnt_idx;
                rr_ptr  <= (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
                sh      <= code[CODE_W-1:1];
                tx_bit  <= code[0];
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                bit_cnt <= bit_cnt + 4'd1;
                tx_bit  <= (bit_cnt == 4'd9) ? 1'b0 : sh[0];
                sh      <= sh >> 1;
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
                tx_bit  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_encode_scheduler.sv
// tb_tx_encode_scheduler: scoreboard bench for tx_encode_scheduler with GAP=1 and GAP=0 instances
module tb_tx_encode_scheduler;
    logic        clk, rst_n;
    logic [3:0]  valid [2];
    logic [27:0] data [2];
    logic [3:0]  ready [2];
    logic        tx_bit [2], tx_en [2], busy [2], frame_done [2];
    logic [9:0]  tx_word [2];
    logic [2:0]  tx_src [2];

    int total = 0, bad = 0, cyc = 0;
    int gap [2] = '{1, 0};
    int m_busy [2], m_ptr [2], rxn [2];
    bit fd_pend [2];
    logic [9:0]  rx [2];
    logic [13:0] q [$];
    logic [13:0] e;
    int gsrc0 [$], gcyc0 [$], gcyc1 [$];
    logic [9:0] rxq0 [$], rxq1 [$];
    int g, fi;
    bit exp_en;
    int ord [5] = '{0, 1, 2, 3, 0};

    tx_encode_scheduler #(.NUM_REQ(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(valid[0]), .req_data(data[0]), .req_ready(ready[0]),
        .tx_bit(tx_bit[0]), .tx_en(tx_en[0]), .tx_word(tx_word[0]), .tx_src(tx_src[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    tx_encode_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid[1]), .req_data(data[1]), .req_ready(ready[1]),
        .tx_bit(tx_bit[1]), .tx_en(tx_en[1]), .tx_word(tx_word[1]), .tx_src(tx_src[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] enc(input logic [6:0] d);
        return {3'b111 ^ 3'($countones(d)), d};
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // cycle model: arbiter, busy window, frame_done timing and frame scoreboard
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_busy[u] = 0; m_ptr[u] = 0; rxn[u] = 0; fd_pend[u] = 0; rx[u] = '0;
                for (int i = q.size() - 1; i >= 0; i--) if (q[i][13] == u[0]) q.delete(i);
            end else begin
                exp_en = m_busy[u] > gap[u];
                chk("frame_done", frame_done[u], fd_pend[u]);
                chk("tx_en", tx_en[u], exp_en);
                chk("busy", busy[u], m_busy[u] > 0);
                if (!exp_en) chk("tx_bit_idle", tx_bit[u], 0);
                fd_pend[u] = (m_busy[u] == gap[u] + 1);
                if (tx_en[u]) begin
                    rx[u][rxn[u]] = tx_bit[u];
                    rxn[u]++;
                    if (rxn[u] == 10) begin
                        fi = -1;
                        for (int i = 0; i < q.size(); i++) if (fi < 0 && q[i][13] == u[0]) fi = i;
                        if (fi < 0) chk("sb_underflow", 1, 0);
                        else begin
                            e = q[fi];
                            q.delete(fi);
                            chk("rx_word", rx[u], e[9:0]);
                            chk("tx_word", tx_word[u], e[9:0]);
                            chk("tx_src", tx_src[u], e[12:10]);
                        end
                        if (u == 0) rxq0.push_back(rx[u]); else rxq1.push_back(rx[u]);
                        rxn[u] = 0; rx[u] = '0;
                    end
                end
                if (m_busy[u] == 0) begin
                    g = rr_pick(valid[u], m_ptr[u]);
                    chk("req_ready", ready[u], g < 0 ? 0 : (1 << g));
                    if (g >= 0) begin
                        q.push_back({u[0], 3'(g), enc(data[u][7*g +: 7])});
                        m_ptr[u] = (g + 1) % 4;
                        m_busy[u] = 10 + gap[u];
                        if (u == 0) begin gsrc0.push_back(g); gcyc0.push_back(cyc); end
                        else gcyc1.push_back(cyc);
                    end
                end else begin
                    chk("ready_busy", ready[u], 0);
                    m_busy[u]--;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int u);
        int t = 0;
        while (m_busy[u] != 0 && t < 200) begin step(1); t++; end
        if (t >= 200) chk("idle_timeout", 0, 1);
    endtask

    task automatic pulse(input int u, input logic [3:0] v, input logic [27:0] d);
        valid[u] = v; data[u] = d;
        step(1);
        valid[u] = '0;
    endtask

    initial begin
        rst_n = 0;
        valid[0] = '0; valid[1] = '0; data[0] = '0; data[1] = '0;
        step(3);
        for (int u = 0; u < 2; u++) begin
            chk("rst_tx_en", tx_en[u], 0);
            chk("rst_busy", busy[u], 0);
            chk("rst_tx_word", tx_word[u], 0);
            chk("rst_tx_src", tx_src[u], 0);
            chk("rst_tx_bit", tx_bit[u], 0);
            chk("rst_ready", ready[u], 0);
        end
        rst_n = 1;
        step(2);

        // all four requesters held valid: 0,1,2,3,0 spaced 12 cycles
        data[0] = {7'h44, 7'h33, 7'h22, 7'h11};
        valid[0] = 4'hf;
        step(49);
        valid[0] = '0;
        chk("rr_count", gsrc0.size(), 5);
        for (int i = 0; i < gsrc0.size() && i < 5; i++) chk("rr_order", gsrc0[i], ord[i]);
        for (int i = 1; i < gcyc0.size(); i++) chk("rr_spacing", gcyc0[i] - gcyc0[i-1], 12);
        wait_idle(0);

        rxq0.delete();
        pulse(0, 4'b0001, 28'h0);
        wait_idle(0);
        chk("zero_word", rxq0.size() > 0 ? 32'(rxq0[0]) : 32'hffffffff, 10'b1110000000);

        rxq0.delete();
        pulse(0, 4'b0010, {7'h0, 7'h0, 7'h7f, 7'h0});
        wait_idle(0);
        pulse(0, 4'b0010, {7'h0, 7'h0, 7'b1010101, 7'h0});
        wait_idle(0);
        chk("ones_word", rxq0.size() > 0 ? 32'(rxq0[0]) : 32'hffffffff, 10'b0001111111);
        chk("alt_word", rxq0.size() > 1 ? 32'(rxq0[1]) : 32'hffffffff, 10'b0111010101);

        // pointer sits at 2: req3 must win before req0
        gsrc0.delete();
        valid[0] = 4'b1001;
        data[0] = {7'h0f, 7'h0, 7'h0, 7'h70};
        step(13);
        valid[0] = '0;
        wait_idle(0);
        chk("wrap_count", gsrc0.size(), 2);
        chk("wrap_first", gsrc0.size() > 0 ? gsrc0[0] : -1, 3);
        chk("wrap_second", gsrc0.size() > 1 ? gsrc0[1] : -1, 0);

        // abort mid-frame at bit 4
        pulse(0, 4'b0100, {7'h0, 7'h5a, 7'h0, 7'h0});
        step(4);
        #2 rst_n = 0;
        #1;
        chk("abort_tx_en", tx_en[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_tx_word", tx_word[0], 0);
        step(1);
        rst_n = 1;
        step(1);
        gsrc0.delete();
        pulse(0, 4'b1001, {7'h21, 7'h0, 7'h0, 7'h12});
        wait_idle(0);
        chk("post_rst_grant", gsrc0.size() > 0 ? gsrc0[0] : -1, 0);

        // GAP_CYCLES=0 instance: back-to-back frames, data changed after accept
        gcyc1.delete(); rxq1.delete();
        data[1] = {7'h0, 7'h0, 7'b1010101, 7'b0000011};
        valid[1] = 4'b0011;
        step(1);
        data[1][6:0] = 7'b1111000;
        step(11);
        valid[1] = '0;
        wait_idle(1);
        chk("g0_count", gcyc1.size(), 2);
        chk("g0_spacing", gcyc1.size() > 1 ? gcyc1[1] - gcyc1[0] : -1, 11);
        chk("g0_word0", rxq1.size() > 0 ? 32'(rxq1[0]) : 32'hffffffff, 10'b1010000011);
        chk("g0_word1", rxq1.size() > 1 ? 32'(rxq1[1]) : 32'hffffffff, 10'b0111010101);

        step(3);
        chk("sb_leftover", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
